// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU: decodes the instruction register
// and sequences FETCH/DCD/EXE/MEM/WB, driving every datapath enable and select.
module mc_ctrl #(
    parameter int W_STATE = 3,
    parameter int RA_IDX  = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ins,
    input  logic               zero,
    input  logic               mem_rdy,
    output logic               PCWr,
    output logic [1:0]         NPCOp,
    output logic               IRWr,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         WbSel,
    output logic               ALUSrc,
    output logic [2:0]         ALUOp,
    output logic [1:0]         ExtOp,
    output logic               OvfChk,
    output logic               MemWr,
    output logic [W_STATE-1:0] state
);

    // jal always targets $31 through RegDst=2; no other link register is wired.
    if (RA_IDX != 31) begin : g_ra_idx_unsupported
        $error("mc_ctrl: only RA_IDX=31 is supported");
    end

    typedef enum logic [W_STATE-1:0] {
        FETCH = 'd0,
        DCD   = 'd1,
        EXE   = 'd2,
        MEM   = 'd3,
        WB    = 'd4
    } state_t;

    state_t state_q, state_d;

    logic [5:0] op, funct;
    logic       unused_ins;
    assign op         = ins[31:26];
    assign funct      = ins[5:0];
    assign unused_ins = ^ins[25:6];

    logic is_addu, is_subu, is_add, is_slt, is_r;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_addu = (op == 6'b000000) && (funct == 6'b100001);
    assign is_subu = (op == 6'b000000) && (funct == 6'b100011);
    assign is_add  = (op == 6'b000000) && (funct == 6'b100000);
    assign is_slt  = (op == 6'b000000) && (funct == 6'b101010);
    assign is_r    = is_addu | is_subu | is_add | is_slt;
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d  = FETCH;
        PCWr     = 1'b0;
        NPCOp    = 2'd0;
        IRWr     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        WbSel    = 2'd0;
        ALUSrc   = 1'b0;
        ALUOp    = 3'd0;
        ExtOp    = 2'd0;
        OvfChk   = 1'b0;
        MemWr    = 1'b0;

        case (state_q)
            FETCH: begin
                PCWr    = 1'b1;
                IRWr    = 1'b1;
                state_d = DCD;
            end
            DCD: begin
                if (is_r | is_ori | is_lui | is_lw | is_sw | is_beq) state_d = EXE;
                else if (is_jal)                                      state_d = WB;
                if (is_j) begin
                    PCWr  = 1'b1;
                    NPCOp = 2'd2;
                end
            end
            EXE: begin
                if (is_r) begin
                    ALUOp   = is_subu ? 3'd1 : (is_slt ? 3'd3 : 3'd0);
                    OvfChk  = is_add;
                    state_d = WB;
                end else if (is_ori | is_lui) begin
                    ALUSrc  = 1'b1;
                    ALUOp   = is_lui ? 3'd4 : 3'd2;
                    state_d = WB;
                end else if (is_lw | is_sw) begin
                    ALUSrc  = 1'b1;
                    ExtOp   = 2'd1;
                    state_d = MEM;
                end else if (is_beq) begin
                    ALUOp = 3'd1;
                    ExtOp = 2'd1;
                    NPCOp = 2'd1;
                    PCWr  = zero;
                end
            end
            MEM: begin
                // Address selects stay stable for the whole stall so memory sees a steady request.
                if (is_lw | is_sw) begin
                    ALUSrc = 1'b1;
                    ExtOp  = 2'd1;
                    MemWr  = is_sw;
                    if (!mem_rdy)   state_d = MEM;
                    else if (is_lw) state_d = WB;
                end
            end
            WB: begin
                if (is_r) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                    OvfChk   = is_add;
                end else if (is_ori | is_lui) begin
                    RegWrite = 1'b1;
                end else if (is_lw) begin
                    RegWrite = 1'b1;
                    WbSel    = 2'd1;
                end else if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    WbSel    = 2'd2;
                    PCWr     = 1'b1;
                    NPCOp    = 2'd2;
                end
            end
            default: state_d = FETCH;
        endcase

        // Reset wins over everything: nothing may be written while it is held.
        if (reset) begin
            PCWr     = 1'b0;
            NPCOp    = 2'd0;
            IRWr     = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 2'd0;
            WbSel    = 2'd0;
            ALUSrc   = 1'b0;
            ALUOp    = 3'd0;
            ExtOp    = 2'd0;
            OvfChk   = 1'b0;
            MemWr    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and
// checks state plus every control output against hand-derived values.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, mem_rdy;
    logic [31:0] ins;
    logic        PCWr, IRWr, RegWrite, ALUSrc, OvfChk, MemWr;
    logic [1:0]  NPCOp, RegDst, WbSel, ExtOp;
    logic [2:0]  ALUOp, state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_rdy(mem_rdy),
        .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RegWrite(RegWrite),
        .RegDst(RegDst), .WbSel(WbSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .ExtOp(ExtOp), .OvfChk(OvfChk), .MemWr(MemWr), .state(state)
    );

    // Field order: PCWr NPCOp IRWr RegWrite RegDst WbSel ALUSrc ALUOp ExtOp OvfChk MemWr
    function automatic logic [16:0] v(int pc, int npc, int ir, int rw, int rd, int wb,
                                      int as, int aop, int ext, int ovf, int mw);
        return {pc[0], npc[1:0], ir[0], rw[0], rd[1:0], wb[1:0], as[0], aop[2:0],
                ext[1:0], ovf[0], mw[0]};
    endfunction

    logic [16:0] outs;
    assign outs = {PCWr, NPCOp, IRWr, RegWrite, RegDst, WbSel, ALUSrc, ALUOp, ExtOp, OvfChk, MemWr};

    logic [16:0] V0, VF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are already set; settle, check, then move to just after the next edge.
    task automatic cyc(input string tag, input int exp_state, input logic [16:0] exp_out);
        #1;
        chk({tag, ".state"}, {29'd0, state}, exp_state);
        chk({tag, ".outs"}, {15'd0, outs}, {15'd0, exp_out});
        @(posedge clk); #1;
    endtask

    initial begin
        V0 = v(0,0,0,0,0,0,0,0,0,0,0);
        VF = v(1,0,1,0,0,0,0,0,0,0,0);
        reset = 1'b1; ins = 32'h00221820; zero = 1'b0; mem_rdy = 1'b0;
        @(posedge clk); #1;
        cyc("rst0", 0, V0);
        cyc("rst1", 0, V0);
        reset = 1'b0;

        // add $3,$1,$2
        cyc("add.F", 0, VF);
        cyc("add.D", 1, V0);
        cyc("add.E", 2, v(0,0,0,0,0,0,0,0,0,1,0));
        cyc("add.W", 4, v(0,0,0,1,1,0,0,0,0,1,0));
        // addu / subu / slt: no overflow check, ALUOp by funct
        ins = 32'h00221821;
        cyc("addu.F", 0, VF); cyc("addu.D", 1, V0);
        cyc("addu.E", 2, V0);
        cyc("addu.W", 4, v(0,0,0,1,1,0,0,0,0,0,0));
        ins = 32'h00221823;
        cyc("subu.F", 0, VF); cyc("subu.D", 1, V0);
        cyc("subu.E", 2, v(0,0,0,0,0,0,0,1,0,0,0));
        cyc("subu.W", 4, v(0,0,0,1,1,0,0,0,0,0,0));
        ins = 32'h0022182A;
        cyc("slt.F", 0, VF); cyc("slt.D", 1, V0);
        cyc("slt.E", 2, v(0,0,0,0,0,0,0,3,0,0,0));
        cyc("slt.W", 4, v(0,0,0,1,1,0,0,0,0,0,0));
        // ori / lui
        ins = 32'h34220005;
        cyc("ori.F", 0, VF); cyc("ori.D", 1, V0);
        cyc("ori.E", 2, v(0,0,0,0,0,0,1,2,0,0,0));
        cyc("ori.W", 4, v(0,0,0,1,0,0,0,0,0,0,0));
        ins = 32'h3C011234;
        cyc("lui.F", 0, VF); cyc("lui.D", 1, V0);
        cyc("lui.E", 2, v(0,0,0,0,0,0,1,4,0,0,0));
        cyc("lui.W", 4, v(0,0,0,1,0,0,0,0,0,0,0));

        // lw with three stalled MEM cycles; mem_rdy high in DCD must be ignored
        ins = 32'h8C220004;
        cyc("lw.F", 0, VF);
        mem_rdy = 1'b1;
        cyc("lw.D", 1, V0);
        mem_rdy = 1'b0;
        cyc("lw.E", 2, v(0,0,0,0,0,0,1,0,1,0,0));
        cyc("lw.M0", 3, v(0,0,0,0,0,0,1,0,1,0,0));
        cyc("lw.M1", 3, v(0,0,0,0,0,0,1,0,1,0,0));
        cyc("lw.M2", 3, v(0,0,0,0,0,0,1,0,1,0,0));
        mem_rdy = 1'b1;
        cyc("lw.M3", 3, v(0,0,0,0,0,0,1,0,1,0,0));
        cyc("lw.W", 4, v(0,0,0,1,0,1,0,0,0,0,0));

        // sw with memory ready immediately
        ins = 32'hAC220004;
        cyc("sw.F", 0, VF); cyc("sw.D", 1, V0);
        cyc("sw.E", 2, v(0,0,0,0,0,0,1,0,1,0,0));
        cyc("sw.M", 3, v(0,0,0,0,0,0,1,0,1,0,1));
        mem_rdy = 1'b0;

        // beq taken, then not taken
        ins = 32'h10220003; zero = 1'b1;
        cyc("beqT.F", 0, VF); cyc("beqT.D", 1, V0);
        cyc("beqT.E", 2, v(1,1,0,0,0,0,0,1,1,0,0));
        zero = 1'b0;
        cyc("beqN.F", 0, VF); cyc("beqN.D", 1, V0);
        cyc("beqN.E", 2, v(0,1,0,0,0,0,0,1,1,0,0));

        // j, jal, unsupported opcode
        ins = 32'h08000010;
        cyc("j.F", 0, VF);
        cyc("j.D", 1, v(1,2,0,0,0,0,0,0,0,0,0));
        ins = 32'h0C000010;
        cyc("jal.F", 0, VF); cyc("jal.D", 1, V0);
        cyc("jal.W", 4, v(1,2,0,1,2,2,0,0,0,0,0));
        ins = 32'hFC000000;
        cyc("bad.F", 0, VF); cyc("bad.D", 1, V0);

        // reset during a stalled sw: no write that cycle, FETCH next
        ins = 32'hAC220004; mem_rdy = 1'b0;
        cyc("swr.F", 0, VF); cyc("swr.D", 1, V0);
        cyc("swr.E", 2, v(0,0,0,0,0,0,1,0,1,0,0));
        cyc("swr.M", 3, v(0,0,0,0,0,0,1,0,1,0,1));
        reset = 1'b1;
        cyc("swr.rst", 3, V0);
        reset = 1'b0;
        cyc("swr.after", 0, VF);
        cyc("swr.D2", 1, V0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
